// File: rtl/hash_tbl_pkg.sv
// Shared constants and FSM state type for the sketch hash-table write path.
package hash_tbl_pkg;

  localparam int unsigned DEPTH1_DEF = 2140;
  localparam int unsigned DEPTH2_DEF = 1070;
  localparam int unsigned DEPTH3_DEF = 535;
  localparam int unsigned AW1_DEF    = 12;
  localparam int unsigned AW2_DEF    = 11;
  localparam int unsigned AW3_DEF    = 10;
  localparam int unsigned DW_DEF     = 4;

  localparam logic [DW_DEF-1:0] CLR_VAL_DEF = 4'h0;

  typedef enum logic {CLEAR, IDLE} state_e;

endpackage

// File: rtl/hash_wport.sv
// One table's B-port driver: range check, clear/update write mux and output registers.
module hash_wport #(
  parameter int unsigned DEPTH = 2140,
  parameter int unsigned AW    = 12,
  parameter int unsigned CW    = 12,
  parameter int unsigned DW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_en,
  input  logic [CW-1:0] clr_addr,
  input  logic [DW-1:0] clr_val,
  input  logic          upd_en,
  input  logic [AW-1:0] upd_addr,
  input  logic [DW-1:0] upd_data,
  output logic          en,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] di,
  output logic          drop
);

  logic          clr_in_range, upd_in_range;
  logic          wr;
  logic [AW-1:0] addr_d, addr_q;
  logic [DW-1:0] data_d, data_q;
  logic          en_q, drop_q;

  assign clr_in_range = 32'(clr_addr) < DEPTH;
  assign upd_in_range = 32'(upd_addr) < DEPTH;

  // Clear and update never overlap: updates are only accepted outside the sweep.
  always_comb begin
    wr     = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (clr_en) begin
      wr = clr_in_range;
      if (clr_in_range) begin
        addr_d = clr_addr[AW-1:0];
        data_d = clr_val;
      end
    end else if (upd_en && upd_in_range) begin
      wr     = 1'b1;
      addr_d = upd_addr;
      data_d = upd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      drop_q <= 1'b0;
    end else begin
      en_q   <= wr;
      addr_q <= addr_d;
      data_q <= data_d;
      drop_q <= upd_en && !clr_en && !upd_in_range;
    end
  end

  assign en   = en_q;
  assign we   = en_q;
  assign addr = addr_q;
  assign di   = data_q;
  assign drop = drop_q;

endmodule

// File: rtl/hash_wr_ctrl.sv
// Write-side controller for the three sketch tables: post-reset/requested clear sweep plus
// valid/ready update commands, one per cycle.
module hash_wr_ctrl #(
  parameter int unsigned    DEPTH1  = hash_tbl_pkg::DEPTH1_DEF,
  parameter int unsigned    DEPTH2  = hash_tbl_pkg::DEPTH2_DEF,
  parameter int unsigned    DEPTH3  = hash_tbl_pkg::DEPTH3_DEF,
  parameter int unsigned    AW1     = hash_tbl_pkg::AW1_DEF,
  parameter int unsigned    AW2     = hash_tbl_pkg::AW2_DEF,
  parameter int unsigned    AW3     = hash_tbl_pkg::AW3_DEF,
  parameter int unsigned    DW      = hash_tbl_pkg::DW_DEF,
  parameter logic [DW-1:0]  CLR_VAL = DW'(hash_tbl_pkg::CLR_VAL_DEF)
) (
  input  logic           Sys_clk,
  input  logic           Rst_n,
  input  logic           Upd_valid,
  output logic           Upd_ready,
  input  logic [2:0]     Upd_sel,
  input  logic [AW1-1:0] Upd_add1,
  input  logic [AW2-1:0] Upd_add2,
  input  logic [AW3-1:0] Upd_add3,
  input  logic [DW-1:0]  Upd_data,
  input  logic           Clr_start,
  output logic           Clr_busy,
  output logic           Clr_done,
  output logic           Drop_err,
  output logic           enb_1,
  output logic           web_1,
  output logic [AW1-1:0] addrb_1,
  output logic [DW-1:0]  dib_1,
  output logic           enb_2,
  output logic           web_2,
  output logic [AW2-1:0] addrb_2,
  output logic [DW-1:0]  dib_2,
  output logic           enb_3,
  output logic           web_3,
  output logic [AW3-1:0] addrb_3,
  output logic [DW-1:0]  dib_3
);

  import hash_tbl_pkg::*;

  state_e         state_d, state_q;
  logic [AW1-1:0] cnt_d, cnt_q;
  logic           done_d, done_q, busy_q;
  logic           clr_en, accept;
  logic [2:0]     upd_en, drop;

  assign Upd_ready = (state_q == IDLE) && !Clr_start;
  assign accept    = Upd_valid && Upd_ready;
  assign clr_en    = (state_q == CLEAR);
  assign upd_en    = {3{accept}} & Upd_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW1'(1);
        if (cnt_q == AW1'(DEPTH1 - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        if (Clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Busy is registered so it lines up with the registered sweep writes.
  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= clr_en;
    end
  end

  assign Clr_busy = busy_q;
  assign Clr_done = done_q;
  assign Drop_err = |drop;

  hash_wport #(.DEPTH(DEPTH1), .AW(AW1), .CW(AW1), .DW(DW)) u_wport_1 (
    .clk      (Sys_clk),
    .rst_n    (Rst_n),
    .clr_en   (clr_en),
    .clr_addr (cnt_q),
    .clr_val  (CLR_VAL),
    .upd_en   (upd_en[0]),
    .upd_addr (Upd_add1),
    .upd_data (Upd_data),
    .en       (enb_1),
    .we       (web_1),
    .addr     (addrb_1),
    .di       (dib_1),
    .drop     (drop[0])
  );

  hash_wport #(.DEPTH(DEPTH2), .AW(AW2), .CW(AW1), .DW(DW)) u_wport_2 (
    .clk      (Sys_clk),
    .rst_n    (Rst_n),
    .clr_en   (clr_en),
    .clr_addr (cnt_q),
    .clr_val  (CLR_VAL),
    .upd_en   (upd_en[1]),
    .upd_addr (Upd_add2),
    .upd_data (Upd_data),
    .en       (enb_2),
    .we       (web_2),
    .addr     (addrb_2),
    .di       (dib_2),
    .drop     (drop[1])
  );

  hash_wport #(.DEPTH(DEPTH3), .AW(AW3), .CW(AW1), .DW(DW)) u_wport_3 (
    .clk      (Sys_clk),
    .rst_n    (Rst_n),
    .clr_en   (clr_en),
    .clr_addr (cnt_q),
    .clr_val  (CLR_VAL),
    .upd_en   (upd_en[2]),
    .upd_addr (Upd_add3),
    .upd_data (Upd_data),
    .en       (enb_3),
    .we       (web_3),
    .addr     (addrb_3),
    .di       (dib_3),
    .drop     (drop[2])
  );

endmodule

// File: tb/tb_hash_wr_ctrl.sv
// Randomized bench for hash_wr_ctrl against a cycle-level behavioural model of the write ports.
module tb_hash_wr_ctrl;

  localparam int D1 = 2140;
  localparam int D2 = 1070;
  localparam int D3 = 535;

  logic        Sys_clk, Rst_n;
  logic        Upd_valid, Upd_ready;
  logic [2:0]  Upd_sel;
  logic [11:0] Upd_add1;
  logic [10:0] Upd_add2;
  logic [9:0]  Upd_add3;
  logic [3:0]  Upd_data;
  logic        Clr_start, Clr_busy, Clr_done, Drop_err;
  logic        enb_1, web_1, enb_2, web_2, enb_3, web_3;
  logic [11:0] addrb_1;
  logic [10:0] addrb_2;
  logic [9:0]  addrb_3;
  logic [3:0]  dib_1, dib_2, dib_3;

  hash_wr_ctrl dut (
    .Sys_clk   (Sys_clk),
    .Rst_n     (Rst_n),
    .Upd_valid (Upd_valid),
    .Upd_ready (Upd_ready),
    .Upd_sel   (Upd_sel),
    .Upd_add1  (Upd_add1),
    .Upd_add2  (Upd_add2),
    .Upd_add3  (Upd_add3),
    .Upd_data  (Upd_data),
    .Clr_start (Clr_start),
    .Clr_busy  (Clr_busy),
    .Clr_done  (Clr_done),
    .Drop_err  (Drop_err),
    .enb_1     (enb_1),
    .web_1     (web_1),
    .addrb_1   (addrb_1),
    .dib_1     (dib_1),
    .enb_2     (enb_2),
    .web_2     (web_2),
    .addrb_2   (addrb_2),
    .dib_2     (dib_2),
    .enb_3     (enb_3),
    .web_3     (web_3),
    .addrb_3   (addrb_3),
    .dib_3     (dib_3)
  );

  initial Sys_clk = 1'b0;
  always #5 Sys_clk = ~Sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: either sweeping (m_clear, at step m_k) or idle taking commands.
  bit m_clear = 1'b1;
  int m_k     = 0;
  int depth[3] = '{D1, D2, D3};
  int n_done   = 0;

  function automatic int in_addr(input int i);
    case (i)
      0:       return int'(Upd_add1);
      1:       return int'(Upd_add2);
      default: return int'(Upd_add3);
    endcase
  endfunction

  function automatic int out_addr(input int i);
    case (i)
      0:       return int'(addrb_1);
      1:       return int'(addrb_2);
      default: return int'(addrb_3);
    endcase
  endfunction

  function automatic int out_data(input int i);
    case (i)
      0:       return int'(dib_1);
      1:       return int'(dib_2);
      default: return int'(dib_3);
    endcase
  endfunction

  always @(posedge Sys_clk) begin
    if (Rst_n) begin
      bit [2:0] e_en;
      int       e_addr[3];
      int       e_dat[3];
      bit       e_done, e_drop, e_busy;
      e_en   = '0;
      e_done = 1'b0;
      e_drop = 1'b0;
      e_busy = m_clear;
      for (int i = 0; i < 3; i++) begin
        e_addr[i] = 0;
        e_dat[i]  = 0;
      end
      if (m_clear) begin
        for (int i = 0; i < 3; i++)
          if (m_k < depth[i]) begin
            e_en[i]   = 1'b1;
            e_addr[i] = m_k;
          end
        e_done = (m_k == D1 - 1);
        m_k++;
        if (m_k == D1) m_clear = 1'b0;
      end else if (Clr_start) begin
        m_clear = 1'b1;
        m_k     = 0;
      end else if (Upd_valid) begin
        for (int i = 0; i < 3; i++)
          if (Upd_sel[i]) begin
            if (in_addr(i) < depth[i]) begin
              e_en[i]   = 1'b1;
              e_addr[i] = in_addr(i);
              e_dat[i]  = int'(Upd_data);
            end else begin
              e_drop = 1'b1;
            end
          end
      end
      #1;
      check("enb", {29'd0, enb_3, enb_2, enb_1}, {29'd0, e_en});
      check("web", {29'd0, web_3, web_2, web_1}, {29'd0, e_en});
      for (int i = 0; i < 3; i++)
        if (e_en[i]) begin
          check($sformatf("addrb_%0d", i + 1), out_addr(i), e_addr[i]);
          check($sformatf("dib_%0d", i + 1), out_data(i), e_dat[i]);
        end
      check("done_drop_busy", {29'd0, Clr_done, Drop_err, Clr_busy},
            {29'd0, e_done, e_drop, e_busy});
      if (Clr_done) n_done++;
    end
  end

  always @(negedge Sys_clk) begin
    #2;
    check("Upd_ready", {31'd0, Upd_ready}, {31'd0, Rst_n && !m_clear && !Clr_start});
  end

  task automatic drive(input bit v, input bit [2:0] s, input int a1, input int a2, input int a3,
                       input bit [3:0] d, input bit c);
    @(negedge Sys_clk);
    Upd_valid = v;
    Upd_sel   = s;
    Upd_add1  = 12'(a1);
    Upd_add2  = 11'(a2);
    Upd_add3  = 10'(a3);
    Upd_data  = d;
    Clr_start = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 3'b000, 0, 0, 0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge Sys_clk);
    Rst_n   = 1'b0;
    m_clear = 1'b1;
    m_k     = 0;
    #1;
    check("rst_enb", {29'd0, enb_3, enb_2, enb_1}, 32'd0);
    check("rst_flags", {29'd0, Clr_done, Drop_err, Clr_busy}, 32'd1);
    check("rst_ready", {31'd0, Upd_ready}, 32'd0);
    @(negedge Sys_clk);
    Rst_n = 1'b1;
  endtask

  // Bounded wait for the model's sweep to end, then confirm the DUT has left it too.
  task automatic wait_sweep(input string tag);
    int n = 0;
    while (m_clear && n < 5000) begin
      idle(1);
      n++;
    end
    idle(1);
    check(tag, {31'd0, Clr_busy}, 32'd0);
  endtask

  initial begin
    Rst_n = 1'b0;
    idle(3);
    check("por_enb", {29'd0, enb_3, enb_2, enb_1}, 32'd0);
    check("por_busy", {31'd0, Clr_busy}, 32'd1);
    @(negedge Sys_clk);
    Rst_n = 1'b1;
    wait_sweep("sweep0_end");
    check("sweep0_done_cnt", n_done, 1);

    // Back-to-back full-mask commands at both ends of every table.
    drive(1'b1, 3'b111, 5, 6, 7, 4'hA, 1'b0);
    drive(1'b1, 3'b111, D1 - 1, D2 - 1, D3 - 1, 4'h3, 1'b0);
    // Out of range in tables 2 and 3 only.
    drive(1'b1, 3'b111, 100, D2, 600, 4'h5, 1'b0);
    drive(1'b1, 3'b000, 1, 1, 1, 4'hF, 1'b0);
    drive(1'b1, 3'b001, D1, 0, 0, 4'h7, 1'b0);
    idle(2);

    // Clear request collides with a command: clear wins.
    drive(1'b1, 3'b111, 9, 9, 9, 4'h9, 1'b1);
    drive(1'b1, 3'b111, 9, 9, 9, 4'h9, 1'b0);
    idle(499);
    drive(1'b0, 3'b000, 0, 0, 0, 4'h0, 1'b1);
    n_done = 0;
    wait_sweep("sweep1_end");
    check("sweep1_done_cnt", n_done, 1);

    // Reset in the middle of a sweep.
    drive(1'b0, 3'b000, 0, 0, 0, 4'h0, 1'b1);
    idle(1000);
    do_reset();
    n_done = 0;
    wait_sweep("sweep2_end");
    check("sweep2_done_cnt", n_done, 1);

    // Random traffic, occasional clear requests.
    for (int i = 0; i < 800; i++)
      drive(($urandom % 4) != 0, 3'($urandom), int'($urandom_range(0, 4095)),
            int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 4'($urandom),
            ($urandom % 400) == 0);
    wait_sweep("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
